change_dispenser: RTL

Sequences coin ejection for the vending controller once a purchase resolves. It accepts the change amount produced by the purchase logic (8-bit cents) and issues a greedy series of quarter/dime/nickel eject requests to the coin hopper under a request/acknowledge handshake. It tracks per-denomination hopper inventory, and reports completion, shortfall and hopper faults back to the controller.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/coin_picker.sv | 31 +++
 rtl/change_dispenser.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending types: cents type, coin values, dispenser states
package vend_pkg;

  // Cents carried between the purchase logic and the change dispenser
  typedef logic [7:0] cents_t;

  // Coin face values in cents
  localparam cents_t NICKEL_C  = 8'd5;
  localparam cents_t DIME_C    = 8'd10;
  localparam cents_t QUARTER_C = 8'd25;

  // Change dispenser sequencing states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE
  } disp_state_t;

  // One-hot coin selection, one bit per hopper eject line
  typedef struct packed {
    logic quarter;
    logic dime;
    logic nickel;
  } coin_sel_t;

endpackage

// File: rtl/coin_picker.sv
// rtl/coin_picker.sv - greedy choice of the largest affordable coin still in stock
module coin_picker
  import vend_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  cents_t           remaining,
  input  logic [CNT_W-1:0] nickel_cnt,
  input  logic [CNT_W-1:0] dime_cnt,
  input  logic [CNT_W-1:0] quarter_cnt,
  output coin_sel_t        sel,
  output cents_t           value
);

  // Largest coin not exceeding what is owed wins; an empty hopper is skipped
  always_comb begin
    sel   = '0;
    value = '0;
    if ((remaining >= QUARTER_C) && (quarter_cnt != '0)) begin
      sel.quarter = 1'b1;
      value       = QUARTER_C;
    end else if ((remaining >= DIME_C) && (dime_cnt != '0)) begin
      sel.dime = 1'b1;
      value    = DIME_C;
    end else if ((remaining >= NICKEL_C) && (nickel_cnt != '0)) begin
      sel.nickel = 1'b1;
      value      = NICKEL_C;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - sequences greedy coin ejection and tracks hopper inventory
module change_dispenser
  import vend_pkg::*;
#(
  parameter int NICKEL_INIT  = 20,
  parameter int DIME_INIT    = 20,
  parameter int QUARTER_INIT = 20,
  parameter int CNT_W        = 6,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [7:0]       change_in,
  input  logic             refill,
  input  logic             hopper_ack,
  output logic             eject_nickel,
  output logic             eject_dime,
  output logic             eject_quarter,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [7:0]       remaining,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] quarter_cnt
);

  localparam int WAIT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  localparam logic [CNT_W-1:0] N_INIT = CNT_W'(NICKEL_INIT);
  localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DIME_INIT);
  localparam logic [CNT_W-1:0] Q_INIT = CNT_W'(QUARTER_INIT);

  disp_state_t       state_q, state_d;
  cents_t            rem_q, rem_d;
  logic [CNT_W-1:0]  n_q, n_d, d_q, d_d, q_q, q_d;
  coin_sel_t         eject_q, eject_d;
  cents_t            coin_val_q, coin_val_d;
  logic              pick_ready_q, pick_ready_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              short_q, short_d;
  logic              fault_q, fault_d;

  coin_sel_t         pick_sel, pick_sel_q;
  cents_t            pick_val, pick_val_q;

  coin_picker #(
    .CNT_W(CNT_W)
  ) u_picker (
    .remaining  (rem_q),
    .nickel_cnt (n_q),
    .dime_cnt   (d_q),
    .quarter_cnt(q_q),
    .sel        (pick_sel),
    .value      (pick_val)
  );

  // Picker result is registered; SELECT spends one cycle letting it settle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pick_sel_q <= '0;
      pick_val_q <= '0;
    end else begin
      pick_sel_q <= pick_sel;
      pick_val_q <= pick_val;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, inventory, remainder and ack wait counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rem_q        <= '0;
      n_q          <= N_INIT;
      d_q          <= D_INIT;
      q_q          <= Q_INIT;
      eject_q      <= '0;
      coin_val_q   <= '0;
      pick_ready_q <= 1'b0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      rem_q        <= rem_d;
      n_q          <= n_d;
      d_q          <= d_d;
      q_q          <= q_d;
      eject_q      <= eject_d;
      coin_val_q   <= coin_val_d;
      pick_ready_q <= pick_ready_d;
      wait_q       <= wait_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      short_q      <= short_d;
      fault_q      <= fault_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    n_d          = n_q;
    d_d          = d_q;
    q_d          = q_q;
    eject_d      = eject_q;
    coin_val_d   = coin_val_q;
    pick_ready_d = pick_ready_q;
    wait_d       = wait_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    short_d      = short_q;
    fault_d      = fault_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (refill) begin
          n_d = N_INIT;
          d_d = D_INIT;
          q_d = Q_INIT;
        end
        if (start) begin
          rem_d        = change_in;
          short_d      = 1'b0;
          fault_d      = 1'b0;
          busy_d       = 1'b1;
          pick_ready_d = 1'b0;
          state_d      = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (!pick_ready_q) begin
          pick_ready_d = 1'b1;
        end else if (pick_sel_q != '0) begin
          eject_d    = pick_sel_q;
          coin_val_d = pick_val_q;
          wait_d     = '0;
          state_d    = ST_EJECT;
        end else begin
          short_d = (rem_q != '0);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_EJECT: begin
        if (hopper_ack) begin
          // The picker only offers a coin that fits and is in stock
          rem_d = rem_q - coin_val_q;
          if (eject_q.quarter) q_d = q_q - CNT_W'(1);
          if (eject_q.dime)    d_d = d_q - CNT_W'(1);
          if (eject_q.nickel)  n_d = n_q - CNT_W'(1);
          eject_d      = '0;
          pick_ready_d = 1'b0;
          state_d      = ST_SELECT;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          short_d = 1'b1;
          eject_d = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign eject_nickel  = eject_q.nickel;
  assign eject_dime    = eject_q.dime;
  assign eject_quarter = eject_q.quarter;
  assign busy          = busy_q;
  assign done          = done_q;
  assign short         = short_q;
  assign fault         = fault_q;
  assign remaining     = rem_q;
  assign nickel_cnt    = n_q;
  assign dime_cnt      = d_q;
  assign quarter_cnt   = q_q;

endmodule
